// File: rtl/fetch_sequencer.sv
// Fetch-side controller: owns the fetch PC and keeps one instruction-memory request in flight.
// It drops responses made stale by an EX redirect and drives the IF/ID stall and flush controls.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        hazard_stall,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F,
   output logic [31:0] InstrF,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushD,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2, S_DISCARD = 2'd3} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_instr_buf, w_buf_nxt;
   logic [31:0] w_target;
   logic [31:0] w_req_addr;
   logic        w_deliver;

   // Request channel: a transfer happens on a rising edge with imem_req_valid & imem_req_ready.
   // Valid stays high until that transfer; the address moves under valid only on a redirect.
   // Response channel is valid-only, exactly one beat per accepted request, never earlier than
   // the cycle after acceptance.
   assign w_target   = PCTargetE & ~32'h3;
   assign w_req_addr = PCSrcE ? w_target : r_pc;
   assign w_deliver  = (((r_state == S_WAIT) & imem_rsp_valid) | (r_state == S_HOLD))
                       & ~PCSrcE & ~hazard_stall;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_REQ;
         r_pc        <= RESET_PC;
         r_instr_buf <= 32'h0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_instr_buf <= w_buf_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_buf_nxt   = r_instr_buf;
      unique case (r_state)
         S_REQ: begin
            // A stray response here is a protocol error and is ignored.
            w_pc_nxt = w_req_addr;
            if (imem_req_ready) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               if (PCSrcE) begin
                  w_pc_nxt    = w_target;
                  w_state_nxt = S_REQ;
               end else if (!hazard_stall) begin
                  w_pc_nxt    = r_pc + 32'd4;
                  w_state_nxt = S_REQ;
               end else begin
                  w_buf_nxt   = imem_rsp_data;
                  w_state_nxt = S_HOLD;
               end
            end else if (PCSrcE) begin
               w_pc_nxt    = w_target;
               w_state_nxt = S_DISCARD;
            end
         end
         S_HOLD: begin
            if (PCSrcE) begin
               w_pc_nxt    = w_target;
               w_state_nxt = S_REQ;
            end else if (!hazard_stall) begin
               w_pc_nxt    = r_pc + 32'd4;
               w_state_nxt = S_REQ;
            end
         end
         S_DISCARD: begin
            // The in-flight response belongs to the abandoned path.
            if (PCSrcE) w_pc_nxt = w_target;
            if (imem_rsp_valid) w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_REQ;
      endcase
   end

   // resetn is folded into the outputs so the pipeline sees a clean bubble while reset is held.
   assign imem_req_valid = resetn & (r_state == S_REQ);
   assign imem_req_addr  = w_req_addr;
   assign InstrF         = w_deliver ? ((r_state == S_WAIT) ? imem_rsp_data : r_instr_buf) : NOP_INSTR;
   assign PCF            = r_pc;
   assign PCPlus4F       = r_pc + 32'd4;
   assign StallF         = ~w_deliver;
   assign StallD         = resetn & hazard_stall;
   assign FlushD         = ~resetn | PCSrcE | (~w_deliver & ~hazard_stall);
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: the main instance starts at PC 0, a second instance
// starts at 0xFFFF_FFFC to exercise PC wrap-around.
module tb_fetch_sequencer;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [1:0]  ST_REQ = 2'd0, ST_WAIT = 2'd1, ST_HOLD = 2'd2, ST_DISCARD = 2'd3;

   logic clk = 1'b0;
   logic resetn;
   logic PCSrcE, hazard_stall, req_ready, rsp_valid;
   logic [31:0] PCTargetE, rsp_data;
   logic req_valid, StallF, StallD, FlushD;
   logic [31:0] req_addr, PCF, PCPlus4F, InstrF;
   logic [1:0] dbg_state;

   logic PCSrcE_w, hazard_w, req_ready_w, rsp_valid_w;
   logic [31:0] PCTargetE_w, rsp_data_w;
   logic req_valid_w, StallF_w, StallD_w, FlushD_w;
   logic [31:0] req_addr_w, PCF_w, PCPlus4F_w, InstrF_w;
   logic [1:0] dbg_state_w;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fetch_sequencer u_dut (
      .clk(clk), .resetn(resetn), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .hazard_stall(hazard_stall), .imem_req_valid(req_valid), .imem_req_addr(req_addr),
      .imem_req_ready(req_ready), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
      .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF), .StallF(StallF), .StallD(StallD),
      .FlushD(FlushD), .o_dbg_state(dbg_state)
   );

   fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) u_dut_wrap (
      .clk(clk), .resetn(resetn), .PCSrcE(PCSrcE_w), .PCTargetE(PCTargetE_w),
      .hazard_stall(hazard_w), .imem_req_valid(req_valid_w), .imem_req_addr(req_addr_w),
      .imem_req_ready(req_ready_w), .imem_rsp_valid(rsp_valid_w), .imem_rsp_data(rsp_data_w),
      .PCF(PCF_w), .PCPlus4F(PCPlus4F_w), .InstrF(InstrF_w), .StallF(StallF_w), .StallD(StallD_w),
      .FlushD(FlushD_w), .o_dbg_state(dbg_state_w)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'h0; hazard_stall = 1'b1;
      req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'h0;
      PCSrcE_w = 1'b0; PCTargetE_w = 32'h0; hazard_w = 1'b0;
      req_ready_w = 1'b0; rsp_valid_w = 1'b0; rsp_data_w = 32'h0;
      #1 resetn = 1'b0;
      #2;
      n_cmp++;
      if ({req_valid, InstrF, StallF, StallD, FlushD, PCF} !== {1'b0, NOP, 1'b1, 1'b0, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected %h", {req_valid, InstrF, StallF, StallD, FlushD, PCF},
                  {1'b0, NOP, 1'b1, 1'b0, 1'b1, 32'h0});
      end
      step();
      n_cmp++;
      if ({dbg_state, req_valid, PCF} !== {ST_REQ, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_held: got %h expected %h", {dbg_state, req_valid, PCF}, {ST_REQ, 1'b0, 32'h0});
      end
      hazard_stall = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      #1;
      n_cmp++;
      if ({req_valid, req_addr, FlushD, StallF} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_first_req: got %h expected %h", {req_valid, req_addr, FlushD, StallF},
                  {1'b1, 32'h0, 1'b1, 1'b1});
      end
   endtask

   task automatic test_basic();
      step();
      rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
      #1;
      n_cmp++;
      if ({InstrF, PCF, PCPlus4F, StallF, FlushD, req_valid} !== {32'h0050_0093, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_deliver: got %h expected %h", {InstrF, PCF, PCPlus4F, StallF, FlushD, req_valid},
                  {32'h0050_0093, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0});
      end
      step();
      rsp_valid = 1'b0;
      #1;
      n_cmp++;
      if ({req_valid, req_addr} !== {1'b1, 32'h4}) begin
         n_fail++;
         $display("FAIL basic_next_req: got %h expected %h", {req_valid, req_addr}, {1'b1, 32'h4});
      end
      step();
      rsp_valid = 1'b1; rsp_data = 32'h0000_0213;
      #1;
      n_cmp++;
      if ({InstrF, PCF, StallF} !== {32'h0000_0213, 32'h4, 1'b0}) begin
         n_fail++;
         $display("FAIL back_to_back: got %h expected %h", {InstrF, PCF, StallF}, {32'h0000_0213, 32'h4, 1'b0});
      end
      req_ready = 1'b0;
      step();
      rsp_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if ({req_valid, req_addr, FlushD, StallF} !== {1'b1, 32'h8, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL backpressure_hold%0d: got %h expected %h", i, {req_valid, req_addr, FlushD, StallF},
                     {1'b1, 32'h8, 1'b1, 1'b1});
         end
         step();
      end
      req_ready = 1'b1;
      #1;
      n_cmp++;
      if ({req_valid, req_addr} !== {1'b1, 32'h8}) begin
         n_fail++;
         $display("FAIL backpressure_accept: got %h expected %h", {req_valid, req_addr}, {1'b1, 32'h8});
      end
      step();
      n_cmp++;
      if ({dbg_state, req_valid} !== {ST_WAIT, 1'b0}) begin
         n_fail++;
         $display("FAIL backpressure_wait: got %h expected %h", {dbg_state, req_valid}, {ST_WAIT, 1'b0});
      end
   endtask

   task automatic test_redirect_wait();
      PCSrcE = 1'b1; PCTargetE = 32'h100;
      #1;
      n_cmp++;
      if ({FlushD, StallF, InstrF} !== {1'b1, 1'b1, NOP}) begin
         n_fail++;
         $display("FAIL redir_wait_flush: got %h expected %h", {FlushD, StallF, InstrF}, {1'b1, 1'b1, NOP});
      end
      step();
      PCSrcE = 1'b0;
      #1;
      n_cmp++;
      if ({dbg_state, req_valid, PCF} !== {ST_DISCARD, 1'b0, 32'h100}) begin
         n_fail++;
         $display("FAIL redir_discard_state: got %h expected %h", {dbg_state, req_valid, PCF},
                  {ST_DISCARD, 1'b0, 32'h100});
      end
      step();
      rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
      #1;
      n_cmp++;
      if ({InstrF, FlushD, StallF} !== {NOP, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL redir_late_rsp_dropped: got %h expected %h", {InstrF, FlushD, StallF}, {NOP, 1'b1, 1'b1});
      end
      step();
      rsp_valid = 1'b0;
      #1;
      n_cmp++;
      if ({dbg_state, req_valid, req_addr} !== {ST_REQ, 1'b1, 32'h100}) begin
         n_fail++;
         $display("FAIL redir_target_req: got %h expected %h", {dbg_state, req_valid, req_addr},
                  {ST_REQ, 1'b1, 32'h100});
      end
      step();
   endtask

   task automatic test_redirect_rsp();
      rsp_valid = 1'b1; rsp_data = 32'h1234_5678; PCSrcE = 1'b1; PCTargetE = 32'h103;
      #1;
      n_cmp++;
      if ({InstrF, FlushD, StallF} !== {NOP, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL redir_rsp_drop: got %h expected %h", {InstrF, FlushD, StallF}, {NOP, 1'b1, 1'b1});
      end
      step();
      rsp_valid = 1'b0; PCSrcE = 1'b0;
      #1;
      n_cmp++;
      if ({dbg_state, req_valid, req_addr} !== {ST_REQ, 1'b1, 32'h100}) begin
         n_fail++;
         $display("FAIL redir_rsp_no_discard: got %h expected %h", {dbg_state, req_valid, req_addr},
                  {ST_REQ, 1'b1, 32'h100});
      end
      step();
   endtask

   task automatic test_hazard_hold();
      rsp_valid = 1'b1; rsp_data = 32'h00A0_0113; hazard_stall = 1'b1;
      #1;
      n_cmp++;
      if ({StallD, FlushD, StallF, InstrF} !== {1'b1, 1'b0, 1'b1, NOP}) begin
         n_fail++;
         $display("FAIL hold_capture: got %h expected %h", {StallD, FlushD, StallF, InstrF}, {1'b1, 1'b0, 1'b1, NOP});
      end
      step();
      rsp_valid = 1'b0; rsp_data = 32'h0;
      #1;
      n_cmp++;
      if ({dbg_state, req_valid, StallD, FlushD} !== {ST_HOLD, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL hold_stay: got %h expected %h", {dbg_state, req_valid, StallD, FlushD},
                  {ST_HOLD, 1'b0, 1'b1, 1'b0});
      end
      step();
      hazard_stall = 1'b0;
      #1;
      n_cmp++;
      if ({InstrF, PCF, StallF, FlushD, StallD} !== {32'h00A0_0113, 32'h100, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL hold_release: got %h expected %h", {InstrF, PCF, StallF, FlushD, StallD},
                  {32'h00A0_0113, 32'h100, 1'b0, 1'b0, 1'b0});
      end
      step();
      n_cmp++;
      if ({req_valid, req_addr} !== {1'b1, 32'h104}) begin
         n_fail++;
         $display("FAIL hold_pc_advance: got %h expected %h", {req_valid, req_addr}, {1'b1, 32'h104});
      end
   endtask

   task automatic test_redirect_req();
      PCSrcE = 1'b1; PCTargetE = 32'h202;
      #1;
      n_cmp++;
      if ({req_valid, req_addr, FlushD} !== {1'b1, 32'h200, 1'b1}) begin
         n_fail++;
         $display("FAIL redir_req_same_cycle: got %h expected %h", {req_valid, req_addr, FlushD},
                  {1'b1, 32'h200, 1'b1});
      end
      step();
      PCSrcE = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h1111_1111;
      #1;
      n_cmp++;
      if ({InstrF, PCF, PCPlus4F} !== {32'h1111_1111, 32'h200, 32'h204}) begin
         n_fail++;
         $display("FAIL redir_req_deliver: got %h expected %h", {InstrF, PCF, PCPlus4F},
                  {32'h1111_1111, 32'h200, 32'h204});
      end
      step();
      rsp_valid = 1'b0;
   endtask

   task automatic test_stall_and_redirect();
      step();
      rsp_valid = 1'b1; rsp_data = 32'h2222_2222; hazard_stall = 1'b1;
      step();
      rsp_valid = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h300;
      #1;
      n_cmp++;
      if ({dbg_state, StallD, FlushD, StallF, InstrF} !== {ST_HOLD, 1'b1, 1'b1, 1'b1, NOP}) begin
         n_fail++;
         $display("FAIL stall_redir_both: got %h expected %h", {dbg_state, StallD, FlushD, StallF, InstrF},
                  {ST_HOLD, 1'b1, 1'b1, 1'b1, NOP});
      end
      step();
      PCSrcE = 1'b0; hazard_stall = 1'b0;
      #1;
      n_cmp++;
      if ({dbg_state, req_valid, req_addr} !== {ST_REQ, 1'b1, 32'h300}) begin
         n_fail++;
         $display("FAIL stall_redir_target: got %h expected %h", {dbg_state, req_valid, req_addr},
                  {ST_REQ, 1'b1, 32'h300});
      end
   endtask

   task automatic test_rsp_in_req();
      req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h3333_3333;
      #1;
      n_cmp++;
      if ({InstrF, StallF, FlushD} !== {NOP, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL rsp_in_req_ignored: got %h expected %h", {InstrF, StallF, FlushD}, {NOP, 1'b1, 1'b1});
      end
      step();
      rsp_valid = 1'b0;
      #1;
      n_cmp++;
      if ({dbg_state, req_addr} !== {ST_REQ, 32'h300}) begin
         n_fail++;
         $display("FAIL rsp_in_req_state: got %h expected %h", {dbg_state, req_addr}, {ST_REQ, 32'h300});
      end
   endtask

   task automatic test_reset_mid();
      req_ready = 1'b1;
      step();
      resetn = 1'b0;
      #1;
      n_cmp++;
      if ({dbg_state, req_valid, PCF, StallF, FlushD, InstrF} !== {ST_REQ, 1'b0, 32'h0, 1'b1, 1'b1, NOP}) begin
         n_fail++;
         $display("FAIL reset_mid: got %h expected %h", {dbg_state, req_valid, PCF, StallF, FlushD, InstrF},
                  {ST_REQ, 1'b0, 32'h0, 1'b1, 1'b1, NOP});
      end
      step();
      @(negedge clk);
      resetn = 1'b1;
      #1;
      n_cmp++;
      if ({req_valid, req_addr} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_mid_restart: got %h expected %h", {req_valid, req_addr}, {1'b1, 32'h0});
      end
   endtask

   task automatic test_wrap();
      req_ready_w = 1'b1;
      #1;
      n_cmp++;
      if ({req_valid_w, req_addr_w} !== {1'b1, 32'hFFFF_FFFC}) begin
         n_fail++;
         $display("FAIL wrap_first_req: got %h expected %h", {req_valid_w, req_addr_w}, {1'b1, 32'hFFFF_FFFC});
      end
      step();
      rsp_valid_w = 1'b1; rsp_data_w = 32'h0010_0093;
      #1;
      n_cmp++;
      if ({InstrF_w, PCF_w, PCPlus4F_w} !== {32'h0010_0093, 32'hFFFF_FFFC, 32'h0}) begin
         n_fail++;
         $display("FAIL wrap_pcplus4: got %h expected %h", {InstrF_w, PCF_w, PCPlus4F_w},
                  {32'h0010_0093, 32'hFFFF_FFFC, 32'h0});
      end
      step();
      rsp_valid_w = 1'b0;
      #1;
      n_cmp++;
      if ({req_valid_w, req_addr_w} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL wrap_next_req: got %h expected %h", {req_valid_w, req_addr_w}, {1'b1, 32'h0});
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_redirect_wait();
      test_redirect_rsp();
      test_hazard_hold();
      test_redirect_req();
      test_stall_and_redirect();
      test_rsp_in_req();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-side controller sitting between the IF stage and a variable-latency instruction memory with valid/ready request and valid-only response channels. It owns the fetch PC and keeps at most one memory request outstanding. It discards responses made stale by an EX-stage redirect. It drives StallF/StallD/FlushD for the IF/ID pipeline register and merges in the hazard unit's load-use stall.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP_INSTR, 32'h0000_0013, instruction presented when nothing is delivered (addi x0,x0,0)

- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- PCSrcE  in  1  branch/jump redirect from EX
- PCTargetE  in  32  redirect target; bits [1:0] cleared internally
- hazard_stall  in  1  load-use stall from hazard unit; freezes F and D
- imem_req_valid  out  1  request valid
- imem_req_addr  out  32  request word address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid; earliest one cycle after acceptance
- imem_rsp_data  in  32  response instruction
- PCF  out  32  address of instruction presented on InstrF
- PCPlus4F  out  32  PCF+4, modulo 2^32
- InstrF  out  32  instruction to IF/ID register
- StallF  out  1  fetch holds
- StallD  out  1  IF/ID register holds
- FlushD  out  1  IF/ID register loads bubble; has priority over StallD downstream

## Operation
- Registers: state, pc_q (32), instr_buf (32).
- States: REQ, WAIT, HOLD, DISCARD.
- "deliver" is the internal signal that is true when an instruction is delivered this cycle:
  - (WAIT & imem_rsp_valid & ~PCSrcE & ~hazard_stall), or
  - (HOLD & ~PCSrcE & ~hazard_stall).
- REQ:
  - imem_req_valid=1; imem_req_addr = PCSrcE ? {PCTargetE[31:2],2'b00} : pc_q.
  - pc_q <= imem_req_addr every cycle.
  - On handshake -> WAIT.
  - imem_rsp_valid is ignored in REQ.
- WAIT:
  - rsp & PCSrcE: drop the data, pc_q<=target -> REQ.
  - rsp & ~hazard_stall: deliver, pc_q<=pc_q+4 -> REQ.
  - rsp & hazard_stall: instr_buf<=data -> HOLD.
  - no rsp & PCSrcE: pc_q<=target -> DISCARD.
- HOLD:
  - PCSrcE: drop the buffer, pc_q<=target -> REQ.
  - ~hazard_stall: deliver instr_buf, pc_q<=pc_q+4 -> REQ.
  - Otherwise stay.
- DISCARD:
  - The next rsp is dropped -> REQ.
  - PCSrcE in DISCARD: pc_q<=target, stay.
- Outputs:
  - InstrF = deliver ? (WAIT ? imem_rsp_data : instr_buf) : NOP_INSTR.
  - PCF = pc_q; PCPlus4F = pc_q+4, so 0xFFFF_FFFC wraps to 0.
  - StallF = ~deliver.
  - StallD = hazard_stall.
  - FlushD = PCSrcE | (~deliver & ~hazard_stall).
- imem_req_valid=0 outside REQ.
- Memory samples address only on handshake. The address changes while valid is high only through a redirect.

## Timing
- Reset (async assert, sync release):
  - state=REQ, pc_q=RESET_PC, instr_buf=0.
  - While resetn=0: imem_req_valid=0, InstrF=NOP_INSTR, StallF=1, StallD=0, FlushD=1, PCF=RESET_PC.
- Reset mid-transaction abandons the outstanding request. Memory shares resetn; no response is expected afterwards.
- Minimum 2 cycles per instruction: accept at n, rsp at n+1, deliver at n+1, next accept at n+2 at the earliest.
- Response-to-InstrF latency is 0 cycles (combinational) in WAIT and 1+ cycles via HOLD.
- A redirect costs no extra cycle in REQ: the target is issued the same cycle. In WAIT without a response, it costs the remaining latency plus 1 cycle for DISCARD.
- Simultaneous PCSrcE and hazard_stall: the redirect wins and the buffered or arriving instruction is dropped. StallD=1 and FlushD=1 together, and the flush takes priority.
- Exactly one response per accepted request. A response in REQ is a protocol error and is ignored.

## Test plan
- Release reset, ready=1, rsp 1 cycle later with 0x00500093 -> accept addr 0x0. Next cycle InstrF=0x00500093, PCF=0x0, PCPlus4F=0x4, StallF=0, FlushD=0. Next request addr 0x4.
- imem_req_ready=0 for 3 cycles at pc 0x8 -> valid held, addr stays 0x8, FlushD=1 and StallF=1 each cycle. Accept on the 4th cycle.
- PCSrcE=1, PCTargetE=0x100 in WAIT with no rsp -> DISCARD. The late rsp 0xDEADBEEF is dropped (InstrF=NOP_INSTR, FlushD=1). Next request addr 0x100.
- PCSrcE=1 with target 0x103 in the same cycle as rsp -> data dropped, FlushD=1. Next cycle is REQ with addr 0x100 and no DISCARD.
- hazard_stall=1 for 2 cycles when rsp 0x00A00113 arrives -> HOLD, StallD=1, FlushD=0, no new request. Stall drops -> InstrF=0x00A00113 delivered, pc advances by 4.
- RESET_PC=0xFFFF_FFFC, rsp arrives -> PCPlus4F=0x0 and the next request addr is 0x0.
